// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB byte-strobed memory slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_w(input int addr_w, input int data_w);
    return addr_w - clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port word RAM: byte-lane synchronous write, asynchronous read.
module apb_sp_ram
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = clog2(DEPTH),
  parameter int STRB_W = strb_w(DATA_W)
) (
  input  logic              pclk,
  input  logic [AW-1:0]     addr,
  input  logic [STRB_W-1:0] we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave fronting a byte-strobed word memory with run-time wait states and
// an error response for out-of-range or misaligned accesses.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT_W = 4,
  parameter int STRB_W = strb_w(DATA_W)
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [1:0]        fsm_state
);

  localparam int OFF_W  = clog2(STRB_W);
  localparam int IDX_W  = idx_w(ADDR_W, DATA_W);
  localparam int RAM_AW = clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_X = DEPTH[IDX_W:0];

  state_t              state, state_n;
  logic [WAIT_W-1:0]   cnt;
  logic [RAM_AW-1:0]   idx_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [IDX_W-1:0]    idx;
  logic                err_setup;
  logic                setup;
  logic                we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [STRB_W-1:0]   ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  assign idx       = paddr[ADDR_W-1:OFF_W];
  // Full-width compare so indices beyond DEPTH never alias onto real words.
  assign err_setup = ({1'b0, idx} >= DEPTH_X) || (paddr[OFF_W-1:0] != '0);
  assign setup     = psel && !penable;

  // Reads happen only while IDLE and writes only while in ACCESS, so one port suffices.
  assign ram_addr  = (state == ACCESS) ? idx_q : idx[RAM_AW-1:0];
  assign ram_we    = we ? strb_q : '0;

  apb_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW),
    .STRB_W (STRB_W)
  ) u_ram (
    .pclk  (pclk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pready  = 1'b0;
    pslverr = 1'b0;
    we      = 1'b0;
    case (state)
      IDLE: begin
        if (setup) state_n = ACCESS;
      end
      ACCESS: begin
        pready  = (cnt == '0);
        pslverr = pready && err_q;
        if (!psel) begin
          state_n = IDLE;
        end else if (penable && cnt == '0) begin
          state_n = IDLE;
          we      = pwrite_q && !err_q;
        end
      end
      default: state_n = IDLE;
    endcase
    prdata = (pready && !pwrite_q && !pslverr) ? rdata_q : '0;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt      <= '0;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (state == IDLE && setup) begin
      cnt      <= wait_cfg;
      idx_q    <= idx[RAM_AW-1:0];
      pwrite_q <= pwrite;
      wdata_q  <= pwdata;
      strb_q   <= pstrb;
      err_q    <= err_setup;
      rdata_q  <= err_setup ? '0 : ram_rdata;
    end else if (state == ACCESS && psel && penable && cnt != '0) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign fsm_state = state;

endmodule
